axi_w_burst_sequencer: RTL and testbench

//  AXI4 write-data (W) channel master sequencer. It queues burst commands (AWLEN),

---
 rtl/axi_w_pkg.sv | 12 +
 rtl/axi_w_cmd_fifo.sv | 44 ++++
 rtl/axi_w_burst_sequencer.sv | 113 +++++++++++
 tb/tb_axi_w_burst_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_w_pkg.sv
// Shared types and default widths for the AXI W-channel burst sequencer.
package axi_w_pkg;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    TRANS,
    DRAIN,
    COMPLETE
  } w_seq_state_e;
endpackage

// File: rtl/axi_w_cmd_fifo.sv
// Synchronous command FIFO holding burst lengths; pointers carry a wrap bit for full/empty.
module axi_w_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/axi_w_burst_sequencer.sv
// AXI4 W-channel master: queues burst lengths, pulls source beats and drives W with WLAST.
module axi_w_burst_sequencer
  import axi_w_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned CMD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [DATA_W-1:0]   src_data,
  input  logic [DATA_W/8-1:0] src_strb,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic                w_valid,
  input  logic                w_ready,
  output logic                busy,
  output logic                burst_done
);
  w_seq_state_e        r_state;
  logic [LEN_W-1:0]    r_remaining;
  logic [DATA_W-1:0]   r_w_data;
  logic [DATA_W/8-1:0] r_w_strb;
  logic                r_w_last;
  logic                r_w_valid;
  logic                r_burst_done;

  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic [LEN_W-1:0]    w_head_len;
  logic                w_src_hs;
  logic                w_w_hs;

  axi_w_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .W     (LEN_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_data  (cmd_len),
    .i_pop   (w_pop),
    .o_data  (w_head_len),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign cmd_ready  = !w_fifo_full;
  assign w_pop      = (r_state == IDLE) && !w_fifo_empty;
  // A new beat may enter only when the output slot is empty or being emptied this cycle.
  assign src_ready  = (r_state == TRANS) && (!r_w_valid || w_ready);
  assign w_src_hs   = src_valid && src_ready;
  assign w_w_hs     = r_w_valid && w_ready;

  assign w_data     = r_w_data;
  assign w_strb     = r_w_strb;
  assign w_last     = r_w_last;
  assign w_valid    = r_w_valid;
  assign burst_done = r_burst_done;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_w_data     <= '0;
      r_w_strb     <= '0;
      r_w_last     <= 1'b0;
      r_w_valid    <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_remaining <= w_head_len;
            r_state     <= TRANS;
          end
        end
        TRANS: begin
          if (w_src_hs) begin
            r_w_data    <= src_data;
            r_w_strb    <= src_strb;
            r_w_valid   <= 1'b1;
            r_w_last    <= (r_remaining == '0);
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == '0) r_state <= DRAIN;
          end else if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_w_hs) begin
            r_w_valid    <= 1'b0;
            r_w_last     <= 1'b0;
            r_burst_done <= 1'b1;
            r_state      <= COMPLETE;
          end
        end
        COMPLETE: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_w_burst_sequencer.sv
// Randomized bench for axi_w_burst_sequencer against a queue-based model of the W stream.
module tb_axi_w_burst_sequencer;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 8;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned MEM = 4096;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          src_valid;
  logic          src_ready;
  logic [DW-1:0] src_data;
  logic [SW-1:0] src_strb;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          w_last;
  logic          w_valid;
  logic          w_ready;
  logic          busy;
  logic          burst_done;

  axi_w_burst_sequencer #(
    .DATA_W    (DW),
    .LEN_W     (LW),
    .CMD_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_strb   (src_strb),
    .w_data     (w_data),
    .w_strb     (w_strb),
    .w_last     (w_last),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .busy       (busy),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source pool and traffic knobs (written by the main sequence only)
  logic [DW-1:0] src_mem  [MEM];
  logic [SW-1:0] strb_mem [MEM];
  int unsigned   src_pct  = 100;
  int unsigned   rdy_pct  = 100;
  bit            rdy_hold0 = 1'b0;

  // Model state (written by the monitor only)
  logic [DW+SW-1:0] data_q[$];
  bit               last_q[$];
  longint unsigned  hs_cyc[$];
  int unsigned      si = 0;
  int unsigned      cmd_beats = 0;
  int unsigned      src_taken = 0;
  int unsigned      hs_count = 0;
  int unsigned      done_count = 0;
  longint unsigned  cyc = 0;
  bit               exp_done = 1'b0;
  logic [DW-1:0]    last_w_data = '0;
  logic [SW-1:0]    last_w_strb = '0;
  bit               prev_v = 1'b0;
  bit               prev_r = 1'b0;
  logic [DW-1:0]    prev_d;
  logic [SW-1:0]    prev_s;
  logic             prev_l;

  always @(posedge clk) begin
    #1;
    src_valid = ($urandom_range(99) < src_pct);
    src_data  = src_mem[si % MEM];
    src_strb  = strb_mem[si % MEM];
    w_ready   = !rdy_hold0 && ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (reset) begin
      data_q.delete();
      last_q.delete();
      cmd_beats = 0;
      src_taken = 0;
      exp_done  = 1'b0;
      prev_v    = 1'b0;
    end else begin
      cyc++;
      check_eq("burst_done", burst_done, exp_done);
      if (burst_done) done_count++;
      exp_done = 1'b0;
      if (prev_v && !prev_r) begin
        check_eq("hold_valid", w_valid, 1);
        check_eq("hold_data", w_data, prev_d);
        check_eq("hold_strb", w_strb, prev_s);
        check_eq("hold_last", w_last, prev_l);
      end
      if (cmd_valid && cmd_ready) begin
        for (int unsigned i = 0; i <= cmd_len; i++) last_q.push_back(i == cmd_len);
        cmd_beats += int'(cmd_len) + 1;
      end
      if (src_valid && src_ready) begin
        check_eq("src_take_in_burst", (src_taken < cmd_beats), 1);
        src_taken++;
        data_q.push_back({src_data, src_strb});
        si++;
      end
      if (w_valid && w_ready) begin
        check_eq("w_beat_expected", (data_q.size() > 0 && last_q.size() > 0), 1);
        if (data_q.size() > 0 && last_q.size() > 0) begin
          logic [DW+SW-1:0] e;
          bit               l;
          e = data_q.pop_front();
          l = last_q.pop_front();
          check_eq("w_data", w_data, e[DW+SW-1:SW]);
          check_eq("w_strb", w_strb, e[SW-1:0]);
          check_eq("w_last", w_last, l);
          if (l) exp_done = 1'b1;
        end
        hs_count++;
        hs_cyc.push_back(cyc);
        last_w_data = w_data;
        last_w_strb = w_strb;
      end
      prev_v = w_valid;
      prev_r = w_ready;
      prev_d = w_data;
      prev_s = w_strb;
      prev_l = w_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int unsigned len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check_eq("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (!busy && !w_valid && last_q.size() == 0) break;
    end
    check_eq("idle_busy", busy, 0);
    check_eq("idle_beats_left", last_q.size(), 0);
    check_eq("idle_data_left", data_q.size(), 0);
  endtask

  initial begin
    int unsigned hb;
    int unsigned db;
    int unsigned sum;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    src_valid = 1'b0;
    src_data  = '0;
    src_strb  = '0;
    w_ready   = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < MEM; i++) begin
      src_mem[i]  = $urandom;
      strb_mem[i] = SW'($urandom);
    end
    #1 reset = 1'b1;
    #2;
    check_eq("rst_w_valid", w_valid, 0);
    check_eq("rst_w_last", w_last, 0);
    check_eq("rst_w_data", w_data, 0);
    check_eq("rst_w_strb", w_strb, 0);
    check_eq("rst_burst_done", burst_done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_src_ready", src_ready, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Full-rate len=3 burst
    hb = hs_count; db = done_count;
    push_cmd(3);
    wait_idle();
    check_eq("t1_beats", hs_count - hb, 4);
    check_eq("t1_consecutive", hs_cyc[hb+3] - hs_cyc[hb], 3);
    check_eq("t1_done", done_count - db, 1);

    // Single-beat burst with a known payload
    src_mem[si % MEM]  = 32'hDEAD_BEEF;
    strb_mem[si % MEM] = 4'hF;
    hb = hs_count; db = done_count;
    push_cmd(0);
    wait_idle();
    check_eq("t2_beats", hs_count - hb, 1);
    check_eq("t2_data", last_w_data, 32'hDEAD_BEEF);
    check_eq("t2_strb", last_w_strb, 4'hF);
    check_eq("t2_done", done_count - db, 1);

    // Backpressure on the first beat of a len=1 burst
    hb = hs_count;
    rdy_hold0 = 1'b1;
    push_cmd(1);
    for (int i = 0; i < 50; i++) begin
      if (w_valid) break;
      tick();
    end
    check_eq("t3_valid_seen", w_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_src_ready_low", src_ready, 0);
      check_eq("t3_valid_held", w_valid, 1);
    end
    rdy_hold0 = 1'b0;
    wait_idle();
    check_eq("t3_beats", hs_count - hb, 2);

    // Fill the queue while W is stalled
    hb = hs_count; db = done_count; sum = 0;
    rdy_hold0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int unsigned l;
      l = $urandom_range(3);
      sum += l + 1;
      push_cmd(l);
    end
    check_eq("t4_full", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_len   = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_full_hold", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rdy_hold0 = 1'b0;
    wait_idle();
    check_eq("t4_beats", hs_count - hb, sum);
    check_eq("t4_done", done_count - db, 5);

    // Reset during beat 2 of a len=7 burst with another command queued
    hb = hs_count;
    push_cmd(7);
    push_cmd(2);
    for (int i = 0; i < 100; i++) begin
      if (hs_count - hb >= 1) break;
      tick();
    end
    check_eq("t5_first_beat", hs_count - hb, 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_w_valid", w_valid, 0);
    check_eq("t5_w_last", w_last, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_cmd_ready", cmd_ready, 1);
    check_eq("t5_burst_done", burst_done, 0);
    tick();
    reset = 1'b0;
    tick();
    hb = hs_count; db = done_count;
    push_cmd(1);
    wait_idle();
    check_eq("t5_beats", hs_count - hb, 2);
    check_eq("t5_done", done_count - db, 1);

    // Maximum length with random gaps on both sides
    src_pct = 60; rdy_pct = 60;
    hb = hs_count; db = done_count;
    push_cmd(255);
    wait_idle();
    check_eq("t6_beats", hs_count - hb, 256);
    check_eq("t6_done", done_count - db, 1);

    // Random mix of bursts and traffic
    hb = hs_count; db = done_count; sum = 0;
    src_pct = $urandom_range(100, 30);
    rdy_pct = $urandom_range(100, 30);
    for (int i = 0; i < 6; i++) begin
      int unsigned l;
      l = $urandom_range(20);
      sum += l + 1;
      push_cmd(l);
    end
    wait_idle();
    check_eq("t7_beats", hs_count - hb, sum);
    check_eq("t7_done", done_count - db, 6);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
